// File: rtl/f3_pd_checker_pkg.sv
// Shared frontend types for the F3 predecode checker: branch-type and fault
// encodings plus the fetch-block geometry.
package f3_pd_checker_pkg;

  localparam int PD_FETCH_WIDTH = 16;
  localparam int PD_IDX_W       = 4;
  localparam int PD_CNT_W       = 16;

  typedef enum logic [1:0] {
    BR_NOTCFI = 2'd0,
    BR_BRANCH = 2'd1,
    BR_JAL    = 2'd2,
    BR_JALR   = 2'd3
  } br_type_e;

  typedef enum logic [1:0] {
    FAULT_NONE   = 2'd0,
    FAULT_JAL    = 2'd1,
    FAULT_RET    = 2'd2,
    FAULT_NOTCFI = 2'd3
  } fault_e;

endpackage

// File: rtl/f3_pd_checker_pd_prio_enc.sv
// Lowest-set-bit priority encoder: returns the index of the least significant
// asserted request and whether any request was present.
module pd_prio_enc #(
  parameter int W     = 16,
  parameter int IDX_W = 4
) (
  input  logic [W-1:0]     req_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             found_o
);

  // Scanning from the top down lets the lowest set bit overwrite the rest.
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        idx_o   = IDX_W'(i);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/f3_pd_checker.sv
// F3 predecode checker: two-stage valid/ready pipeline comparing predecoded
// jumps/returns with the BPU taken slot and producing a corrected taken slot.
module f3_pd_checker
  import f3_pd_checker_pkg::*;
#(
  parameter int FETCH_WIDTH = PD_FETCH_WIDTH,
  parameter int IDX_W       = PD_IDX_W,
  parameter int CNT_W       = PD_CNT_W
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2*FETCH_WIDTH-1:0] in_brType,
  input  logic [FETCH_WIDTH-1:0]   in_isCall,
  input  logic [FETCH_WIDTH-1:0]   in_isRet,
  input  logic [FETCH_WIDTH-1:0]   in_instrRange,
  input  logic                     in_predTakenValid,
  input  logic [IDX_W-1:0]         in_predTakenIdx,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [1:0]               out_fault,
  output logic                     out_fixedTakenValid,
  output logic [IDX_W-1:0]         out_fixedTakenIdx,
  output logic                     out_fixedIsCall,
  output logic                     out_fixedIsRet,
  output logic [CNT_W-1:0]         fault_cnt
);

  logic                   s1_valid_q, s1_valid_d;
  logic                   out_valid_q, out_valid_d;
  logic                   s2_ready, s1_load, s2_load;

  logic [FETCH_WIDTH-1:0] jal_mask_d, ret_mask_d, cfi_mask_d;
  logic [FETCH_WIDTH-1:0] jal_mask_q, ret_mask_q, cfi_mask_q;
  logic [FETCH_WIDTH-1:0] is_call_q, is_ret_q;
  logic                   pred_v_q;
  logic [IDX_W-1:0]       pred_idx_q;
  br_type_e               bt;

  logic [FETCH_WIDTH-1:0] jmp_mask, after_mask;
  logic [IDX_W-1:0]       first_idx, after_idx;
  logic                   first_found, after_found, early, pred_bad;
  fault_e                 fault_d;
  logic                   fix_v_d, fix_call_d, fix_ret_d;
  logic [IDX_W-1:0]       fix_idx_d;

  logic [1:0]             out_fault_q;
  logic                   out_fix_v_q, out_call_q, out_ret_q;
  logic [IDX_W-1:0]       out_fix_idx_q;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  assign s2_ready = !out_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s2_ready;
  assign s1_load  = in_valid && in_ready;
  assign s2_load  = s1_valid_q && s2_ready;

  // S1: in-range slot classification.
  always_comb begin
    jal_mask_d = '0;
    ret_mask_d = '0;
    cfi_mask_d = '0;
    bt         = BR_NOTCFI;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      bt            = br_type_e'(in_brType[2*i +: 2]);
      jal_mask_d[i] = in_instrRange[i] && (bt == BR_JAL);
      ret_mask_d[i] = in_instrRange[i] && (bt == BR_JALR) && in_isRet[i];
      cfi_mask_d[i] = in_instrRange[i] && (bt != BR_NOTCFI);
    end
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    if (flush)        s1_valid_d = 1'b0;
    else if (s1_load) s1_valid_d = 1'b1;
    else if (s2_ready) s1_valid_d = 1'b0;
  end

  // Payload registers carry no reset; only the valid bits qualify them.
  always_ff @(posedge clock) begin
    if (s1_load) begin
      jal_mask_q <= jal_mask_d;
      ret_mask_q <= ret_mask_d;
      cfi_mask_q <= cfi_mask_d;
      is_call_q  <= in_isCall;
      is_ret_q   <= in_isRet;
      pred_v_q   <= in_predTakenValid;
      pred_idx_q <= in_predTakenIdx;
    end
  end

  // S2: resolve against the prediction.
  assign jmp_mask = jal_mask_q | ret_mask_q;

  always_comb begin
    after_mask = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      after_mask[i] = jmp_mask[i] && (IDX_W'(i) > pred_idx_q);
    end
  end

  pd_prio_enc #(.W(FETCH_WIDTH), .IDX_W(IDX_W)) u_first_enc (
    .req_i   (jmp_mask),
    .idx_o   (first_idx),
    .found_o (first_found)
  );

  pd_prio_enc #(.W(FETCH_WIDTH), .IDX_W(IDX_W)) u_after_enc (
    .req_i   (after_mask),
    .idx_o   (after_idx),
    .found_o (after_found)
  );

  assign early    = first_found && (!pred_v_q || (first_idx < pred_idx_q));
  assign pred_bad = pred_v_q && !cfi_mask_q[pred_idx_q];

  always_comb begin
    fault_d   = FAULT_NONE;
    fix_v_d   = pred_v_q;
    fix_idx_d = pred_idx_q;
    if (early) begin
      fault_d   = jal_mask_q[first_idx] ? FAULT_JAL : FAULT_RET;
      fix_v_d   = 1'b1;
      fix_idx_d = first_idx;
    end else if (pred_bad) begin
      fault_d   = FAULT_NOTCFI;
      fix_v_d   = after_found;
      fix_idx_d = after_idx;
    end
    if (!fix_v_d) fix_idx_d = '0;
    fix_call_d = fix_v_d && is_call_q[fix_idx_d];
    fix_ret_d  = fix_v_d && is_ret_q[fix_idx_d];
  end

  always_comb begin
    out_valid_d = out_valid_q;
    if (flush)          out_valid_d = 1'b0;
    else if (s2_load)   out_valid_d = 1'b1;
    else if (out_ready) out_valid_d = 1'b0;
  end

  // A delivered fault is counted even on a flush cycle; saturates at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (out_valid_q && out_ready && (out_fault_q != FAULT_NONE) && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_valid_q    <= 1'b0;
      out_valid_q   <= 1'b0;
      out_fault_q   <= FAULT_NONE;
      out_fix_v_q   <= 1'b0;
      out_fix_idx_q <= '0;
      out_call_q    <= 1'b0;
      out_ret_q     <= 1'b0;
      cnt_q         <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      out_valid_q <= out_valid_d;
      cnt_q       <= cnt_d;
      if (s2_load) begin
        out_fault_q   <= fault_d;
        out_fix_v_q   <= fix_v_d;
        out_fix_idx_q <= fix_idx_d;
        out_call_q    <= fix_call_d;
        out_ret_q     <= fix_ret_d;
      end
    end
  end

  assign out_valid           = out_valid_q;
  assign out_fault           = out_fault_q;
  assign out_fixedTakenValid = out_fix_v_q;
  assign out_fixedTakenIdx   = out_fix_idx_q;
  assign out_fixedIsCall     = out_call_q;
  assign out_fixedIsRet      = out_ret_q;
  assign fault_cnt           = cnt_q;

endmodule

// File: doc/f3_pd_checker.md
# f3_pd_checker

Frontend F3 predecode checker: consumes the per-slot predecode results (brType/isCall/isRet) for one 16-slot fetch block, compares them against the BPU's predicted taken slot, and emits a registered fault classification plus a corrected taken slot for the redirect logic. Sits directly downstream of the F3 predecoder and upstream of the F3 redirect/RAS-fix stage. Two-stage valid/ready pipeline with flush and a saturating fault counter.

## Interface
- FETCH_WIDTH, 16, slots per fetch block
- IDX_W, 4, slot index width (log2 FETCH_WIDTH)
- CNT_W, 16, fault counter width
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high
- flush  in  1  drop all in-flight blocks
- in_valid  in  1  input block valid
- in_ready  out  1  checker can accept block
- in_brType  in  2*FETCH_WIDTH  slot i at [2i+1:2i]; 0 notCFI, 1 branch, 2 jal, 3 jalr
- in_isCall  in  FETCH_WIDTH  per-slot call flag
- in_isRet  in  FETCH_WIDTH  per-slot return flag
- in_instrRange  in  FETCH_WIDTH  slot lies inside the fetch range
- in_predTakenValid  in  1  BPU predicted a taken slot
- in_predTakenIdx  in  IDX_W  predicted taken slot
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_fault  out  2  0 none, 1 jalFault, 2 retFault, 3 notCFITaken
- out_fixedTakenValid  out  1  corrected block has a taken slot
- out_fixedTakenIdx  out  IDX_W  corrected taken slot
- out_fixedIsCall / out_fixedIsRet  out  1 each  flags of corrected slot
- fault_cnt  out  CNT_W  faults delivered since reset

## Operation
- S1 (capture): on in_valid && in_ready latch inputs; build in-range one-hot masks jalMask (brType==2), retMask (brType==3 && isRet), cfiMask (brType!=0); in_ready = !s1_valid || s2_ready.
- S2 (resolve): on s1_valid && s2_ready; s2_ready = !out_valid || out_ready.
  - firstJmp = lowest index set in jalMask|retMask; "early" = exists and (!predTakenValid or firstJmp < predTakenIdx).
  - early: fault = jalFault if slot is jal else retFault; fixed = firstJmp.
  - else if predTakenValid and (slot out of range or cfiMask bit clear): fault = notCFITaken; fixed = firstJmp if one exists after pred slot, else fixedTakenValid=0.
  - else: fault = none; fixed = prediction (valid = predTakenValid).
  - fixedIsCall/IsRet taken from in_isCall/in_isRet at fixed slot; 0 when fixedTakenValid=0.
  - firstJmp == predTakenIdx is not a fault.
- fault_cnt: +1 on out_valid && out_ready && out_fault!=0; saturates at all-ones; unaffected by flush.
- flush: clears s1_valid and out_valid next edge; an input presented with flush is dropped even if in_ready=1; in_ready itself not gated by flush.

## Timing
- Latency 2 cycles input handshake to out_valid, no backpressure; throughput 1 block/cycle.
- Reset: s1_valid=0, out_valid=0, in_ready=1, out_fault=0, out_fixedTakenValid=0, out_fixedTakenIdx=0, flags 0, fault_cnt=0.
- Output payload stable while out_valid && !out_ready.
- Full: both stages valid and out_ready=0 -> in_ready=0 same cycle (combinational from out_ready).
- Simultaneous out handshake and S1 advance: S2 reloads same edge, no bubble.
- Reset mid-stream discards all blocks immediately.

## Structure
- Shared frontend package: BrType enum (notCFI/branch/jal/jalr), fault enum, FETCH_WIDTH/IDX_W constants.
- One sub-module: pd_prio_enc (lowest-set-bit priority encoder, FETCH_WIDTH in, IDX_W index + found out), used for firstJmp and first-after-pred search.

## Test plan
- Reset held then released: all outputs at reset values, in_ready=1.
- All slots in range, jal at 7, pred 7 -> fault 0, fixed 7, valid 1, out_valid 2 cycles after accept.
- jal at 3 with isCall, pred 9 -> fault 1, fixed 3, fixedIsCall=1, fault_cnt 0->1.
- ret (jalr+isRet) at 5, no prediction -> fault 2, fixed 5, fixedIsRet=1.
- pred 10 on notCFI slot, no jal/ret anywhere -> fault 3, fixedTakenValid 0; pred 12 with instrRange[12]=0 and jal at 14 -> fault 3, fixed 14.
- out_ready low 4 cycles with 4 back-to-back blocks: 2 accepted, in_ready=0, order preserved; flush mid-stall -> out_valid=0 next cycle, fault_cnt unchanged; CNT_W=2 with 5 faults -> fault_cnt=3.
